// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multi-cycle CPU control unit: state codes,
// opcode constants, PC source selects and the decoded opcode class.
package mc_ctrl_pkg;

   typedef enum logic [2:0] {
      ST_IF   = 3'd0,
      ST_ID   = 3'd1,
      ST_EXE  = 3'd2,
      ST_MEM  = 3'd3,
      ST_WB   = 3'd4,
      ST_HALT = 3'd5
   } state_t;

   localparam logic [5:0] OP_R    = 6'h00;
   localparam logic [5:0] OP_ADDI = 6'h08;
   localparam logic [5:0] OP_LW   = 6'h23;
   localparam logic [5:0] OP_SW   = 6'h2B;
   localparam logic [5:0] OP_BEQ  = 6'h04;
   localparam logic [5:0] OP_J    = 6'h02;
   localparam logic [5:0] OP_HALT = 6'h3F;

   localparam logic [1:0] PC_SRC_SEQ = 2'd0;
   localparam logic [1:0] PC_SRC_BR  = 2'd1;
   localparam logic [1:0] PC_SRC_JMP = 2'd2;

   typedef struct packed {
      logic is_r;
      logic is_addi;
      logic is_lw;
      logic is_sw;
      logic is_beq;
      logic is_j;
      logic is_halt;
      logic is_nop;
   } op_class_t;

endpackage

// File: rtl/mc_ctrl_fsm_decode.sv
// Opcode classifier: one-hot class flags for the control FSM.
// Anything that is not a recognised opcode is treated as a NOP.
module mc_op_decode
   import mc_ctrl_pkg::*;
#(
   parameter int OP_WIDTH = 6
) (
   input  logic [OP_WIDTH-1:0] op,
   output op_class_t           cls
);

   always_comb begin
      cls         = '0;
      cls.is_r    = (op == OP_WIDTH'(OP_R));
      cls.is_addi = (op == OP_WIDTH'(OP_ADDI));
      cls.is_lw   = (op == OP_WIDTH'(OP_LW));
      cls.is_sw   = (op == OP_WIDTH'(OP_SW));
      cls.is_beq  = (op == OP_WIDTH'(OP_BEQ));
      cls.is_j    = (op == OP_WIDTH'(OP_J));
      cls.is_halt = (op == OP_WIDTH'(OP_HALT));
      cls.is_nop  = !(cls.is_r || cls.is_addi || cls.is_lw || cls.is_sw ||
                      cls.is_beq || cls.is_j || cls.is_halt);
   end

endmodule

// File: rtl/mc_ctrl_fsm.sv
// Multi-cycle CPU control FSM: sequences IF/ID/EXE/MEM/WB, runs the memory
// req/ack handshake and counts retired instructions.
//
//   state | meaning
//   IF    | fetch request out, wait for mem_ack, load IR and PC+4
//   ID    | decode; J/NOP retire here, HALT enters HALT
//   EXE   | ALU operation; BEQ resolves branch and retires
//   MEM   | data access for LW/SW, wait for mem_ack
//   WB    | register-file write, retire
//   HALT  | absorbing, only reset leaves
module mc_ctrl_fsm
   import mc_ctrl_pkg::*;
#(
   parameter int OP_WIDTH  = 6,
   parameter int CNT_WIDTH = 32
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [OP_WIDTH-1:0]  op,
   input  logic                 zero,
   input  logic                 mem_ack,
   output logic [2:0]           state,
   output logic                 pc_we,
   output logic [1:0]           pc_src,
   output logic                 ir_we,
   output logic                 reg_we,
   output logic                 reg_dst,
   output logic                 wb_sel,
   output logic                 alu_src_b,
   output logic                 mem_req,
   output logic                 mem_we,
   output logic                 halted,
   output logic [CNT_WIDTH-1:0] instr_cnt
);

   state_t    state_q;
   op_class_t cls;
   logic      retire;

   mc_op_decode #(
      .OP_WIDTH (OP_WIDTH)
   ) u_decode (
      .op  (op),
      .cls (cls)
   );

   // A retirement is any transition back to IF that completes an
   // instruction, plus the single entry into HALT.
   always_comb begin
      retire = 1'b0;
      case (state_q)
         ST_ID:   retire = cls.is_j || cls.is_nop || cls.is_halt;
         ST_EXE:  retire = cls.is_beq;
         ST_MEM:  retire = mem_ack && cls.is_sw;
         ST_WB:   retire = 1'b1;
         default: retire = 1'b0;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_IF;
         instr_cnt <= '0;
      end else begin
         if (retire) instr_cnt <= instr_cnt + CNT_WIDTH'(1);
         case (state_q)
            ST_IF:   if (mem_ack) state_q <= ST_ID;
            ST_ID: begin
               if (cls.is_j || cls.is_nop) state_q <= ST_IF;
               else if (cls.is_halt)       state_q <= ST_HALT;
               else                        state_q <= ST_EXE;
            end
            ST_EXE: begin
               if (cls.is_beq)                  state_q <= ST_IF;
               else if (cls.is_lw || cls.is_sw) state_q <= ST_MEM;
               else                             state_q <= ST_WB;
            end
            ST_MEM:  if (mem_ack) state_q <= cls.is_sw ? ST_IF : ST_WB;
            ST_WB:   state_q <= ST_IF;
            ST_HALT: state_q <= ST_HALT;
            default: state_q <= ST_IF;
         endcase
      end
   end

   // Moore decode of state/op; the IF enables and the EXE branch enable are
   // qualified combinationally by mem_ack and zero in their own cycle.
   always_comb begin
      state     = state_q;
      pc_we     = 1'b0;
      pc_src    = PC_SRC_SEQ;
      ir_we     = 1'b0;
      reg_we    = 1'b0;
      reg_dst   = 1'b0;
      wb_sel    = 1'b0;
      alu_src_b = 1'b0;
      mem_req   = 1'b0;
      mem_we    = 1'b0;
      halted    = 1'b0;
      case (state_q)
         ST_IF: begin
            mem_req = 1'b1;
            if (mem_ack) begin
               ir_we  = 1'b1;
               pc_we  = 1'b1;
               pc_src = PC_SRC_SEQ;
            end
         end
         ST_ID: begin
            if (cls.is_j) begin
               pc_we  = 1'b1;
               pc_src = PC_SRC_JMP;
            end
         end
         ST_EXE: begin
            alu_src_b = cls.is_addi || cls.is_lw || cls.is_sw;
            if (cls.is_beq) begin
               pc_we  = zero;
               pc_src = PC_SRC_BR;
            end
         end
         ST_MEM: begin
            mem_req = 1'b1;
            mem_we  = cls.is_sw;
         end
         ST_WB: begin
            reg_we  = 1'b1;
            reg_dst = cls.is_r;
            wb_sel  = cls.is_lw;
         end
         ST_HALT: halted = 1'b1;
         default: ;
      endcase
   end

endmodule
